boron_enc_cntrl: RTL and testbench

- Control and sequencing block for BORON encryption: 64-bit block, 80-bit key, 25 rounds.
- Loads the plaintext and master key, then iterates an external combinational round function and key-schedule step once per cycle for ROUNDS cycles.
- Applies the final whitening XOR, presents the ciphertext and the last round key, and holds them until the consumer acknowledges.
- The last round key is the starting key for the decryption path.

---
 rtl/boron_enc_cntrl.sv | 135 +++++++++++++
 tb/tb_boron_enc_cntrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boron_enc_cntrl.sv
// BORON encryption sequencer: loads a block and key, steps the external round/key-schedule ROUNDS times, whitens and holds the result.
// Optional BORON_ENC_ABORT_EN adds an abort input that cancels an in-flight operation.
module boron_enc_cntrl #(
    parameter int ROUNDS = 25,
    parameter int TEXT_W = 64,
    parameter int KEY_W  = 80,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [TEXT_W-1:0] plain_text,
    input  logic [KEY_W-1:0]  key,
    input  logic [TEXT_W-1:0] round_text,
    input  logic [KEY_W-1:0]  next_key,
    input  logic              out_ack,
`ifdef BORON_ENC_ABORT_EN
    input  logic              abort,
`endif
    output logic [TEXT_W-1:0] current_text,
    output logic [KEY_W-1:0]  current_key,
    output logic [CNT_W-1:0]  round_cnt,
    output logic              busy,
    output logic              fin,
    output logic [TEXT_W-1:0] cipher_text,
    output logic [KEY_W-1:0]  last_key
);

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        WHITEN,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   abort_req;
    logic   last_round;

`ifdef BORON_ENC_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign last_round = (round_cnt == CNT_W'(ROUNDS - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ROUND;
                end
            end
            ROUND: begin
                if (abort_req) begin
                    state_nxt = IDLE;
                end else if (last_round) begin
                    state_nxt = WHITEN;
                end
            end
            WHITEN: begin
                if (abort_req) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The result registers are written only in WHITEN, so they survive IDLE and aborts.
    always_ff @(posedge clk) begin
        if (!reset) begin
            current_text <= '0;
            current_key  <= '0;
            round_cnt    <= '0;
            cipher_text  <= '0;
            last_key     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        current_text <= plain_text;
                        current_key  <= key;
                        round_cnt    <= '0;
                    end
                end
                ROUND: begin
                    if (abort_req) begin
                        current_text <= '0;
                        current_key  <= '0;
                        round_cnt    <= '0;
                    end else begin
                        current_text <= round_text;
                        current_key  <= next_key;
                        round_cnt    <= round_cnt + CNT_W'(1);
                    end
                end
                WHITEN: begin
                    if (abort_req) begin
                        current_text <= '0;
                        current_key  <= '0;
                        round_cnt    <= '0;
                    end else begin
                        cipher_text <= current_text ^ current_key[TEXT_W-1:0];
                        last_key    <= current_key;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state == ROUND) || (state == WHITEN);
    assign fin  = (state == DONE);

endmodule

// File: tb/tb_boron_enc_cntrl.sv
// Self-checking bench for boron_enc_cntrl using an incrementing round/key-schedule stub.
// A closed-form model (result = inputs advanced by min(age, ROUNDS)) is compared every cycle, plus directed literal checks.
module tb_boron_enc_cntrl;

    localparam int ROUNDS = 25;
    localparam int TEXT_W = 64;
    localparam int KEY_W  = 80;
    localparam int CNT_W  = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [TEXT_W-1:0] plain_text = '0;
    logic [KEY_W-1:0]  key = '0;
    logic [TEXT_W-1:0] round_text;
    logic [KEY_W-1:0]  next_key;
    logic              out_ack = 1'b0;
`ifdef BORON_ENC_ABORT_EN
    logic              abort = 1'b0;
`endif
    logic [TEXT_W-1:0] current_text;
    logic [KEY_W-1:0]  current_key;
    logic [CNT_W-1:0]  round_cnt;
    logic              busy;
    logic              fin;
    logic [TEXT_W-1:0] cipher_text;
    logic [KEY_W-1:0]  last_key;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int busy_cnt = 0;
    int fin_hi_cnt = 0;
    int fin_rises = 0;
    bit fin_prev = 1'b0;

    always #5 clk = ~clk;

    assign round_text = current_text + TEXT_W'(1);
    assign next_key   = current_key + KEY_W'(1);

    boron_enc_cntrl #(
        .ROUNDS(ROUNDS),
        .TEXT_W(TEXT_W),
        .KEY_W (KEY_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .plain_text  (plain_text),
        .key         (key),
        .round_text  (round_text),
        .next_key    (next_key),
        .out_ack     (out_ack),
`ifdef BORON_ENC_ABORT_EN
        .abort       (abort),
`endif
        .current_text(current_text),
        .current_key (current_key),
        .round_cnt   (round_cnt),
        .busy        (busy),
        .fin         (fin),
        .cipher_text (cipher_text),
        .last_key    (last_key)
    );

    task automatic checkOutput(input string name, input logic [KEY_W-1:0] act, input logic [KEY_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40) begin
                $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
            end
        end
    endtask

    task automatic applyStimulus(input bit s, input logic [TEXT_W-1:0] p, input logic [KEY_W-1:0] k, input bit ack);
        start      = s;
        plain_text = p;
        key        = k;
        out_ack    = ack;
    endtask

    task automatic waitFin(output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (fin === 1'b1) begin
                at_cyc = cyc;
                break;
            end
        end
        if (at_cyc < 0) begin
            checkOutput("fin_timeout", 0, 1);
        end
    endtask

    task automatic waitRound(input int n);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (round_cnt == CNT_W'(n)) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            checkOutput("round_wait_timeout", 0, 1);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (busy === 1'b1) busy_cnt++;
        if (fin === 1'b1) fin_hi_cnt++;
        if (fin === 1'b1 && !fin_prev) fin_rises++;
        fin_prev = (fin === 1'b1);
    end

    // Model: age counts edges since the accepting start; every architectural value is a function of age.
    bit                m_valid = 1'b0;
    bit                m_idle = 1'b1;
    int                m_age = 0;
    int                m_steps;
    logic [TEXT_W-1:0] m_plain = '0;
    logic [KEY_W-1:0]  m_key0 = '0;
    logic [TEXT_W-1:0] m_text = '0;
    logic [KEY_W-1:0]  m_key = '0;
    int                m_cnt = 0;
    logic [TEXT_W-1:0] m_cipher = '0;
    logic [KEY_W-1:0]  m_last = '0;
    logic [TEXT_W-1:0] m_ftext;
    logic [KEY_W-1:0]  m_fkey;
    bit                m_abort;

    always @(posedge clk) begin
        m_abort = 1'b0;
`ifdef BORON_ENC_ABORT_EN
        m_abort = (abort === 1'b1);
`endif
        if (reset === 1'b0) begin
            m_valid = 1'b1;
            m_idle = 1'b1;
            m_age = 0;
            m_text = '0;
            m_key = '0;
            m_cnt = 0;
            m_cipher = '0;
            m_last = '0;
        end else if (m_valid) begin
            if (m_idle) begin
                if (start === 1'b1) begin
                    m_idle = 1'b0;
                    m_age = 0;
                    m_plain = plain_text;
                    m_key0 = key;
                end
            end else if (m_age <= ROUNDS && m_abort) begin
                m_idle = 1'b1;
                m_text = '0;
                m_key = '0;
                m_cnt = 0;
            end else if (m_age <= ROUNDS) begin
                m_age++;
                if (m_age == ROUNDS + 1) begin
                    m_ftext = m_plain + TEXT_W'(ROUNDS);
                    m_fkey = m_key0 + KEY_W'(ROUNDS);
                    m_cipher = m_ftext ^ m_fkey[TEXT_W-1:0];
                    m_last = m_fkey;
                end
            end else if (out_ack === 1'b1) begin
                m_idle = 1'b1;
            end
            if (!m_idle) begin
                m_steps = (m_age < ROUNDS) ? m_age : ROUNDS;
                m_text = m_plain + TEXT_W'(m_steps);
                m_key = m_key0 + KEY_W'(m_steps);
                m_cnt = m_steps;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("model_current_text", current_text, m_text);
            checkOutput("model_current_key", current_key, m_key);
            checkOutput("model_round_cnt", round_cnt, m_cnt);
            checkOutput("model_busy", busy, !m_idle && m_age <= ROUNDS);
            checkOutput("model_fin", fin, !m_idle && m_age > ROUNDS);
            checkOutput("model_cipher_text", cipher_text, m_cipher);
            checkOutput("model_last_key", last_key, m_last);
        end
    end

    initial begin
        int accept_cyc;
        int f1;
        int f2;

        applyStimulus(0, '0, '0, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_current_text", current_text, 0);
        checkOutput("reset_round_cnt", round_cnt, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_fin", fin, 0);
        checkOutput("reset_cipher_text", cipher_text, 0);
        checkOutput("reset_last_key", last_key, 0);
        reset = 1'b1;
        @(negedge clk);

        // Single block: fin first seen on the 27th edge counting the accepting edge as the first.
        $display("[TB] single block");
        busy_cnt = 0;
        applyStimulus(1, 64'h0, 80'h100, 0);
        @(negedge clk);
        start = 1'b0;
        accept_cyc = cyc;
        checkOutput("accept_round_cnt", round_cnt, 0);
        checkOutput("accept_busy", busy, 1);
        checkOutput("accept_current_key", current_key, 80'h100);
        waitFin(f1);
        checkOutput("fin_latency", f1 - accept_cyc, 26);
        checkOutput("single_cipher", cipher_text, 64'h100);
        checkOutput("single_last_key", last_key, 80'h119);
        checkOutput("single_busy_cycles", busy_cnt, 26);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("hold_fin", fin, 1);
            checkOutput("hold_cipher", cipher_text, 64'h100);
        end
        out_ack = 1'b1;
        @(negedge clk);
        checkOutput("ack_fin_drop", fin, 0);
        out_ack = 1'b0;
        @(negedge clk);

        // Back-to-back with start and out_ack held high.
        $display("[TB] back-to-back");
        fin_hi_cnt = 0;
        applyStimulus(1, 64'h0, 80'h100, 1);
        waitFin(f1);
        @(negedge clk);
        waitFin(f2);
        start = 1'b0;
        repeat (3) @(negedge clk);
        out_ack = 1'b0;
        checkOutput("b2b_spacing", f2 - f1, 28);
        checkOutput("b2b_fin_width", fin_hi_cnt, 2);
        checkOutput("b2b_cipher", cipher_text, 64'h100);
        checkOutput("b2b_last_key", last_key, 80'h119);

        // start pulsed mid-operation is ignored.
        $display("[TB] start during ROUND");
        fin_rises = 0;
        applyStimulus(1, 64'h55, 80'h200, 0);
        @(negedge clk);
        start = 1'b0;
        waitRound(5);
        applyStimulus(1, 64'hFFFF, 80'hFFFF, 0);
        @(negedge clk);
        start = 1'b0;
        checkOutput("ignored_start_round_cnt", round_cnt, 6);
        checkOutput("ignored_start_text", current_text, 64'h5B);
        waitFin(f1);
        checkOutput("ignored_start_cipher", cipher_text, 64'h277);
        checkOutput("ignored_start_last_key", last_key, 80'h219);
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("ignored_start_fin_count", fin_rises, 1);

        // Reset in the middle of an operation, then a fresh operation with upper key bits set.
        $display("[TB] reset mid-round");
        applyStimulus(1, 64'h1, 80'h1, 0);
        @(negedge clk);
        start = 1'b0;
        waitRound(12);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checkOutput("midreset_text", current_text, 0);
        checkOutput("midreset_key", current_key, 0);
        checkOutput("midreset_round_cnt", round_cnt, 0);
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_cipher", cipher_text, 0);
        checkOutput("midreset_last_key", last_key, 0);
        @(negedge clk);
        applyStimulus(1, 64'h1234, 80'hDEAD_0000_0000_0000_ABCD, 0);
        @(negedge clk);
        start = 1'b0;
        waitFin(f1);
        checkOutput("post_reset_cipher", cipher_text, 64'hB9AB);
        checkOutput("post_reset_last_key", last_key, 80'hDEAD_0000_0000_0000_ABE6);
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
        @(negedge clk);

`ifdef BORON_ENC_ABORT_EN
        $display("[TB] abort");
        fin_rises = 0;
        applyStimulus(1, 64'h10, 80'h20, 0);
        @(negedge clk);
        start = 1'b0;
        waitRound(20);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_round_cnt", round_cnt, 0);
        checkOutput("abort_text", current_text, 0);
        checkOutput("abort_cipher_kept", cipher_text, 64'hB9AB);
        repeat (30) @(negedge clk);
        checkOutput("abort_no_fin", fin_rises, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
